// File: rtl/apu_pkg.sv
// Shared APU definitions: envelope direction encoding and default envelope bank sizing.
package apu_pkg;

  typedef enum logic {
    ENV_DECAY  = 1'b0,
    ENV_ATTACK = 1'b1
  } env_dir_t;

  localparam int ENV_VOL_W  = 4;
  localparam int ENV_PER_W  = 4;
  localparam int ENV_NUM_CH = 3;

endpackage

// File: rtl/envelope_bank_if.sv
// Register-file-side and mixer-side signals of the envelope bank, bundled per bank.
interface envelope_bank_if
  import apu_pkg::*;
#(
  parameter int NUM_CH = ENV_NUM_CH,
  parameter int VOL_W  = ENV_VOL_W,
  parameter int PER_W  = ENV_PER_W
);

  logic                    cpu_clk_en;
  logic                    quarter_clk_en;
  logic [NUM_CH-1:0]       load;
  logic [NUM_CH-1:0]       loop_flag;
  logic [NUM_CH-1:0]       const_vol;
  logic [NUM_CH-1:0]       attack;
  logic [NUM_CH*PER_W-1:0] period;
  logic [NUM_CH*VOL_W-1:0] vol_in;
  logic [NUM_CH*VOL_W-1:0] vol_out;
  logic [NUM_CH-1:0]       done;

  modport master (
    output cpu_clk_en, quarter_clk_en, load, loop_flag, const_vol, attack, period, vol_in,
    input  vol_out, done
  );

  modport slave (
    input  cpu_clk_en, quarter_clk_en, load, loop_flag, const_vol, attack, period, vol_in,
    output vol_out, done
  );

endinterface

// File: rtl/envelope_channel.sv
// One envelope voice: restart flag, period divider and up/down level counter
// advanced by the quarter-frame tick.
module envelope_channel
  import apu_pkg::*;
#(
  parameter int VOL_W = ENV_VOL_W,
  parameter int PER_W = ENV_PER_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_clk_en,
  input  logic             quarter_clk_en,
  input  logic             load,
  input  logic             loop_flag,
  input  logic             const_vol,
  input  logic             attack,
  input  logic [PER_W-1:0] period,
  input  logic [VOL_W-1:0] vol_in,
  output logic [VOL_W-1:0] vol_out,
  output logic             done
);

  localparam logic [VOL_W-1:0] VOL_MAX = {VOL_W{1'b1}};

  env_dir_t         dir;
  logic             start;
  logic [PER_W-1:0] div;
  logic [VOL_W-1:0] level;
  logic [VOL_W-1:0] step_level;

  assign dir = env_dir_t'(attack);

  // Saturate at the terminal level unless looping, which jumps to the opposite end.
  always_comb begin
    step_level = level;
    if (dir == ENV_ATTACK) begin
      if (level != VOL_MAX) step_level = level + 1'b1;
      else if (loop_flag)   step_level = '0;
    end else begin
      if (level != '0)      step_level = level - 1'b1;
      else if (loop_flag)   step_level = VOL_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start <= 1'b0;
      div   <= '0;
      level <= '0;
    end else begin
      if (quarter_clk_en) begin
        if (start) begin
          level <= (dir == ENV_ATTACK) ? '0 : VOL_MAX;
          div   <= period;
        end else if (div != '0) begin
          div <= div - 1'b1;
        end else begin
          div   <= period;
          level <= step_level;
        end
      end
      // A load landing on a tick keeps start set so the restart lands on the next tick.
      if (cpu_clk_en && load) start <= 1'b1;
      else if (quarter_clk_en) start <= 1'b0;
    end
  end

  assign vol_out = const_vol ? vol_in : level;
  assign done    = ~start & ~loop_flag & (level == ((dir == ENV_ATTACK) ? VOL_MAX : '0));

endmodule

// File: rtl/envelope_bank.sv
// Multi-channel volume envelope generator: one envelope_channel per voice,
// sliced out of the packed register-file buses.
module envelope_bank
  import apu_pkg::*;
#(
  parameter int NUM_CH = ENV_NUM_CH,
  parameter int VOL_W  = ENV_VOL_W,
  parameter int PER_W  = ENV_PER_W
) (
  input logic           clk,
  input logic           rst,
  envelope_bank_if.slave bus
);

  logic [NUM_CH*VOL_W-1:0] vol_out_w;
  logic [NUM_CH-1:0]       done_w;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    envelope_channel #(
      .VOL_W (VOL_W),
      .PER_W (PER_W)
    ) u_ch (
      .clk            (clk),
      .rst            (rst),
      .cpu_clk_en     (bus.cpu_clk_en),
      .quarter_clk_en (bus.quarter_clk_en),
      .load           (bus.load[i]),
      .loop_flag      (bus.loop_flag[i]),
      .const_vol      (bus.const_vol[i]),
      .attack         (bus.attack[i]),
      .period         (bus.period[i*PER_W +: PER_W]),
      .vol_in         (bus.vol_in[i*VOL_W +: VOL_W]),
      .vol_out        (vol_out_w[i*VOL_W +: VOL_W]),
      .done           (done_w[i])
    );
  end

  assign bus.vol_out = vol_out_w;
  assign bus.done    = done_w;

endmodule

// File: tb/tb_envelope_bank.sv
// Scoreboard bench for envelope_bank: directed envelope scenarios followed by
// randomized traffic, all checked against a per-channel reference model.
module tb_envelope_bank;
  import apu_pkg::*;

  localparam int NUM_CH = 3;
  localparam int VOL_W  = 4;
  localparam int PER_W  = 4;
  localparam int VMAX   = (1 << VOL_W) - 1;

  logic clk = 1'b0;
  logic rst;

  envelope_bank_if #(.NUM_CH(NUM_CH), .VOL_W(VOL_W), .PER_W(PER_W)) bus ();

  envelope_bank #(.NUM_CH(NUM_CH), .VOL_W(VOL_W), .PER_W(PER_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  logic              s_rst, s_cpu, s_qtr;
  logic [NUM_CH-1:0] s_load, s_loop, s_const, s_attack;
  logic [PER_W-1:0]  s_period [NUM_CH];
  logic [VOL_W-1:0]  s_vol_in [NUM_CH];

  bit m_start [NUM_CH];
  int m_wait  [NUM_CH];
  int m_level [NUM_CH];

  typedef struct {
    logic [NUM_CH*VOL_W-1:0] vol;
    logic [NUM_CH-1:0]       done;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   stim_done = 0;

  // Reference: a countdown of quarter ticks until the next level step.
  task automatic model_step(input int i);
    if (s_rst) begin
      m_start[i] = 0;
      m_wait[i]  = 0;
      m_level[i] = 0;
    end else begin
      if (s_qtr) begin
        if (m_start[i]) begin
          m_level[i] = s_attack[i] ? 0 : VMAX;
          m_wait[i]  = int'(s_period[i]);
        end else if (m_wait[i] > 0) begin
          m_wait[i] = m_wait[i] - 1;
        end else begin
          m_wait[i] = int'(s_period[i]);
          if (s_attack[i]) begin
            if (m_level[i] < VMAX) m_level[i] = m_level[i] + 1;
            else if (s_loop[i])    m_level[i] = 0;
          end else begin
            if (m_level[i] > 0)    m_level[i] = m_level[i] - 1;
            else if (s_loop[i])    m_level[i] = VMAX;
          end
        end
      end
      if (s_cpu && s_load[i]) m_start[i] = 1;
      else if (s_qtr)         m_start[i] = 0;
    end
  endtask

  task automatic apply_stimulus();
    exp_t e;
    @(negedge clk);
    rst                = s_rst;
    bus.cpu_clk_en     = s_cpu;
    bus.quarter_clk_en = s_qtr;
    bus.load           = s_load;
    bus.loop_flag      = s_loop;
    bus.const_vol      = s_const;
    bus.attack         = s_attack;
    for (int i = 0; i < NUM_CH; i++) begin
      bus.period[i*PER_W +: PER_W] = s_period[i];
      bus.vol_in[i*VOL_W +: VOL_W] = s_vol_in[i];
      model_step(i);
      e.vol[i*VOL_W +: VOL_W] = s_const[i] ? s_vol_in[i] : VOL_W'(m_level[i]);
      e.done[i] = !m_start[i] && !s_loop[i] && (m_level[i] == (s_attack[i] ? VMAX : 0));
    end
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic check_output(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("[TB] FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  function automatic int ch_vol(input int ch);
    return int'(bus.vol_out[ch*VOL_W +: VOL_W]);
  endfunction

  task automatic tick();
    s_rst = 0; s_cpu = 0; s_qtr = 1; s_load = '0;
    apply_stimulus();
  endtask

  task automatic do_load(input logic [NUM_CH-1:0] mask);
    s_rst = 0; s_cpu = 1; s_qtr = 0; s_load = mask;
    apply_stimulus();
    s_cpu = 0; s_load = '0;
  endtask

  // Monitor: every cycle the outputs are compared against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.vol_out !== e.vol || bus.done !== e.done) begin
          failures++;
          $display("[TB] FAIL scoreboard vol_out got=%h want=%h done got=%b want=%b",
                   bus.vol_out, e.vol, bus.done, e.done);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog stimulus did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    s_rst = 1; s_cpu = 0; s_qtr = 0; s_load = '0;
    s_loop = '0; s_const = '1; s_attack = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      s_period[i] = '0;
      s_vol_in[i] = VOL_W'(i + 9);
    end

    apply_stimulus();
    check_output("reset_const_vol", ch_vol(0), 9);
    s_rst = 0; s_const = '0;
    apply_stimulus();
    check_output("reset_level_zero", ch_vol(0), 0);
    check_output("reset_done", int'(bus.done[0]), 1);

    s_period[0] = PER_W'(2);
    do_load(3'b001);
    for (int t = 1; t <= 49; t++) begin
      tick();
      if (t == 1)  check_output("decay_tick1", ch_vol(0), 15);
      if (t == 4)  check_output("decay_tick4", ch_vol(0), 14);
      if (t == 45) check_output("decay_tick45", ch_vol(0), 1);
      if (t == 46) check_output("decay_tick46", ch_vol(0), 0);
      if (t == 46) check_output("decay_done", int'(bus.done[0]), 1);
      if (t == 49) check_output("decay_hold", ch_vol(0), 0);
    end

    s_loop[0] = 1; s_period[0] = '0;
    do_load(3'b001);
    for (int t = 1; t <= 17; t++) begin
      tick();
      if (t == 1)  check_output("loop_tick1", ch_vol(0), 15);
      if (t == 16) check_output("loop_tick16", ch_vol(0), 0);
      if (t == 16) check_output("loop_done_low", int'(bus.done[0]), 0);
      if (t == 17) check_output("loop_reload", ch_vol(0), 15);
    end

    s_loop[0] = 0; s_attack[0] = 1;
    do_load(3'b001);
    for (int t = 1; t <= 17; t++) begin
      tick();
      if (t == 1)  check_output("attack_tick1", ch_vol(0), 0);
      if (t == 16) check_output("attack_tick16", ch_vol(0), 15);
      if (t == 17) check_output("attack_hold", ch_vol(0), 15);
      if (t == 17) check_output("attack_done", int'(bus.done[0]), 1);
    end
    do_load(3'b001);
    for (int t = 1; t <= 8; t++) tick();
    check_output("attack_mid", ch_vol(0), 7);
    s_attack[0] = 0;
    tick();
    check_output("attack_flip", ch_vol(0), 6);

    do_load(3'b001);
    for (int t = 1; t <= 11; t++) tick();
    check_output("collide_pre", ch_vol(0), 5);
    s_cpu = 1; s_load = 3'b001; s_qtr = 1;
    apply_stimulus();
    check_output("collide_no_restart", ch_vol(0), 4);
    tick();
    check_output("collide_restart", ch_vol(0), 15);

    s_period[0] = PER_W'(1); s_period[1] = PER_W'(2); s_period[2] = PER_W'(3);
    s_attack = 3'b010; s_loop = 3'b100;
    do_load(3'b111);
    for (int t = 1; t <= 7; t++) tick();
    do_load(3'b010);
    for (int t = 1; t <= 5; t++) tick();

    for (int n = 0; n < 1500; n++) begin
      s_rst = ($urandom_range(0, 399) == 0);
      s_cpu = $urandom_range(0, 1);
      s_qtr = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < NUM_CH; i++) begin
        s_load[i] = ($urandom_range(0, 11) == 0);
        if ($urandom_range(0, 15) == 0) s_loop[i]   = ~s_loop[i];
        if ($urandom_range(0, 15) == 0) s_attack[i] = ~s_attack[i];
        if ($urandom_range(0, 31) == 0) s_const[i]  = ~s_const[i];
        if ($urandom_range(0, 31) == 0) s_period[i] = PER_W'($urandom_range(0, (1 << PER_W) - 1));
        s_vol_in[i] = VOL_W'($urandom_range(0, VMAX));
      end
      apply_stimulus();
    end

    repeat (3) @(posedge clk);
    #3;
    check_output("queue_drained", exp_q.size(), 0);
    stim_done = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
